// File: rtl/opb_register_simulink2ppc_snap.sv
`default_nettype none
// ============================================================================
// Module      : opb_register_simulink2ppc_snap
// Description : OPB slave that snapshots a 32-bit fabric value on each valid
//               strobe and exposes it, plus sticky new-data/overflow flags and
//               a 16-bit capture counter, to the PowerPC.
// Revision    : 1.0 - initial release
// ============================================================================
module opb_register_simulink2ppc_snap #(
    parameter logic [31:0] C_BASEADDR   = 32'hFFFFFFFF,
    parameter logic [31:0] C_HIGHADDR   = 32'h00000000,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter              C_FAMILY     = "virtex5"
) (
    input  logic                        OPB_Clk,
    input  logic                        OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1]     OPB_ABus,
    input  logic [0:C_OPB_DWIDTH/8-1]   OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]     OPB_DBus,
    input  logic                        OPB_RNW,
    input  logic                        OPB_select,
    input  logic                        OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]     Sl_DBus,
    output logic                        Sl_xferAck,
    output logic                        Sl_errAck,
    output logic                        Sl_retry,
    output logic                        Sl_toutSup,
    input  logic [31:0]                 user_data_in,
    input  logic                        user_data_valid
);

    // Snapshot state
    logic [31:0] r_data;
    logic        r_new_data;
    logic        r_overflow;
    logic [15:0] r_cap_cnt;

    // Bus response registers
    logic        r_xfer_ack;
    logic [31:0] r_rd_data;

    // Decode / control
    logic        w_hit;
    logic        w_start;
    logic        w_is_status;
    logic        w_rd_data;
    logic        w_wr_status;
    logic        w_clr_new;
    logic        w_clr_ovf;
    logic [31:0] w_status;

    // The full 32-bit address is compared against the window; ABus[29] picks
    // DATA/STATUS and the two byte-offset bits are don't-care.
    assign w_hit       = OPB_select && (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
    // A new transfer may only start when we are not acking this cycle, which
    // forces an idle cycle between back-to-back acks.
    assign w_start     = w_hit && !r_xfer_ack;
    assign w_is_status = OPB_ABus[29];
    assign w_rd_data   = w_start && OPB_RNW && !w_is_status;
    assign w_wr_status = w_start && !OPB_RNW && w_is_status && OPB_BE[3];
    // OPB bit 31 is the LSB: write value 0x1 clears new_data, 0x2 clears overflow.
    assign w_clr_new   = w_rd_data || (w_wr_status && OPB_DBus[31]);
    assign w_clr_ovf   = w_wr_status && OPB_DBus[30];
    assign w_status    = {r_cap_cnt, 14'd0, r_overflow, r_new_data};

    // Acknowledge one cycle after a hit and register the read word for that cycle.
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            r_xfer_ack <= 1'b0;
            r_rd_data  <= 32'd0;
        end else begin
            r_xfer_ack <= w_start;
            if (w_start && OPB_RNW) begin
                r_rd_data <= w_is_status ? w_status : r_data;
            end else begin
                r_rd_data <= 32'd0;
            end
        end
    end

    // Capture fabric samples; a capture always beats a same-edge clear.
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            r_data     <= 32'd0;
            r_new_data <= 1'b0;
            r_overflow <= 1'b0;
            r_cap_cnt  <= 16'd0;
        end else if (user_data_valid) begin
            r_data     <= user_data_in;
            r_new_data <= 1'b1;
            r_cap_cnt  <= r_cap_cnt + 16'd1;
            if (r_new_data) begin
                r_overflow <= 1'b1;
            end else if (w_clr_ovf) begin
                r_overflow <= 1'b0;
            end
        end else begin
            if (w_clr_new) begin
                r_new_data <= 1'b0;
            end
            if (w_clr_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Fabric MSB lands on OPB bit 0, which is a plain MSB-to-MSB assignment.
    assign Sl_DBus    = r_rd_data;
    assign Sl_xferAck = r_xfer_ack;
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

    // Inputs that carry no meaning for this slave.
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, OPB_seqAddr, OPB_BE[0:2], OPB_DBus[0:29], C_FAMILY[0]};

endmodule
`default_nettype wire

// File: tb/tb_opb_register_simulink2ppc_snap.sv
`default_nettype none
// ============================================================================
// Module      : tb_opb_register_simulink2ppc_snap
// Description : Directed plus randomized bench for the fabric->PPC snapshot
//               register, checked against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_opb_register_simulink2ppc_snap;

    localparam logic [31:0] C_BASE = 32'h8000_1000;
    localparam logic [31:0] C_HIGH = 32'h8000_10FF;
    localparam logic [31:0] C_DATA_ADDR = C_BASE;
    localparam logic [31:0] C_STAT_ADDR = C_BASE + 32'h4;

    logic        OPB_Clk = 1'b0;
    logic        OPB_Rst;
    logic [0:31] OPB_ABus;
    logic [0:3]  OPB_BE;
    logic [0:31] OPB_DBus;
    logic        OPB_RNW;
    logic        OPB_select;
    logic        OPB_seqAddr;
    logic [0:31] Sl_DBus;
    logic        Sl_xferAck;
    logic        Sl_errAck;
    logic        Sl_retry;
    logic        Sl_toutSup;
    logic [31:0] user_data_in;
    logic        user_data_valid;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model state
    logic [31:0] m_data;
    bit          m_new;
    bit          m_ovf;
    int          m_cnt;
    bit          m_ack;

    opb_register_simulink2ppc_snap #(
        .C_BASEADDR   (C_BASE),
        .C_HIGHADDR   (C_HIGH),
        .C_OPB_AWIDTH (32),
        .C_OPB_DWIDTH (32),
        .C_FAMILY     ("virtex5")
    ) dut (
        .OPB_Clk         (OPB_Clk),
        .OPB_Rst         (OPB_Rst),
        .OPB_ABus        (OPB_ABus),
        .OPB_BE          (OPB_BE),
        .OPB_DBus        (OPB_DBus),
        .OPB_RNW         (OPB_RNW),
        .OPB_select      (OPB_select),
        .OPB_seqAddr     (OPB_seqAddr),
        .Sl_DBus         (Sl_DBus),
        .Sl_xferAck      (Sl_xferAck),
        .Sl_errAck       (Sl_errAck),
        .Sl_retry        (Sl_retry),
        .Sl_toutSup      (Sl_toutSup),
        .user_data_in    (user_data_in),
        .user_data_valid (user_data_valid)
    );

    always #5 OPB_Clk = ~OPB_Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Predict the effect of the current inputs at the next edge, clock it, and
    // compare the bus outputs one delta later.
    task automatic step();
        logic [31:0] a;
        logic [31:0] wd;
        bit          hit, e_ack, clr_new, clr_ovf, is_stat, be_low;
        logic [31:0] e_dbus;
        a       = OPB_ABus;
        wd      = OPB_DBus;
        be_low  = (OPB_BE & 4'b0001) != 4'b0000;
        is_stat = (a & 32'h4) != 0;
        hit     = OPB_select && (a >= C_BASE) && (a <= C_HIGH);
        e_dbus  = 32'd0;
        e_ack   = 1'b0;
        if (OPB_Rst) begin
            m_data = 32'd0; m_new = 0; m_ovf = 0; m_cnt = 0;
        end else begin
            e_ack   = hit && !m_ack;
            clr_new = 0;
            clr_ovf = 0;
            if (e_ack && OPB_RNW) begin
                if (is_stat) begin
                    e_dbus = m_cnt * 65536 + (m_ovf ? 2 : 0) + (m_new ? 1 : 0);
                end else begin
                    e_dbus  = m_data;
                    clr_new = 1;
                end
            end else if (e_ack && is_stat && be_low) begin
                clr_new = (wd & 32'h1) != 0;
                clr_ovf = (wd & 32'h2) != 0;
            end
            if (user_data_valid) begin
                m_ovf  = m_new ? 1'b1 : (clr_ovf ? 1'b0 : m_ovf);
                m_new  = 1;
                m_data = user_data_in;
                m_cnt  = (m_cnt + 1) % 65536;
            end else begin
                if (clr_new) m_new = 0;
                if (clr_ovf) m_ovf = 0;
            end
        end
        m_ack = e_ack;
        @(posedge OPB_Clk);
        #1;
        check("xferAck", {31'd0, Sl_xferAck}, {31'd0, e_ack});
        check("Sl_DBus", Sl_DBus, e_dbus);
        check("tied_outs", {29'd0, Sl_errAck, Sl_retry, Sl_toutSup}, 32'd0);
    endtask

    task automatic opb_read(input logic [31:0] addr, output logic [31:0] data);
        OPB_select = 1'b1;
        OPB_RNW    = 1'b1;
        OPB_ABus   = addr;
        step();
        check("rd_ack", {31'd0, Sl_xferAck}, 32'd1);
        data = Sl_DBus;
        OPB_select = 1'b0;
        step();
    endtask

    task automatic opb_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        OPB_select = 1'b1;
        OPB_RNW    = 1'b0;
        OPB_ABus   = addr;
        OPB_DBus   = data;
        OPB_BE     = be;
        step();
        OPB_select = 1'b0;
        OPB_DBus   = 32'd0;
        OPB_BE     = 4'd0;
        step();
    endtask

    task automatic capture(input logic [31:0] v);
        user_data_valid = 1'b1;
        user_data_in    = v;
        step();
        user_data_valid = 1'b0;
    endtask

    task automatic do_reset();
        OPB_Rst = 1'b1;
        step();
        step();
        OPB_Rst = 1'b0;
    endtask

    // Directed scenarios followed by a randomized soak.
    initial begin
        logic [31:0] rd;
        logic [31:0] last;
        logic [5:0]  acks;
        int          r;

        m_data = 32'd0; m_new = 0; m_ovf = 0; m_cnt = 0; m_ack = 0;
        OPB_Rst = 1'b1; OPB_ABus = 32'd0; OPB_BE = 4'd0; OPB_DBus = 32'd0;
        OPB_RNW = 1'b0; OPB_select = 1'b0; OPB_seqAddr = 1'b0;
        user_data_in = 32'd0; user_data_valid = 1'b0;
        #1;
        do_reset();

        // Reset state
        opb_read(C_STAT_ADDR, rd);
        check("reset_status", rd, 32'h0000_0000);

        // Single capture, then read
        capture(32'hDEAD_BEEF);
        opb_read(C_DATA_ADDR, rd);
        check("data_deadbeef", rd, 32'hDEAD_BEEF);
        opb_read(C_STAT_ADDR, rd);
        check("status_after_read", rd, 32'h0001_0000);

        // Two unread captures -> overflow
        do_reset();
        capture(32'h1);
        capture(32'h2);
        opb_read(C_STAT_ADDR, rd);
        check("status_overflow", rd, 32'h0002_0003);
        opb_read(C_DATA_ADDR, rd);
        check("data_latest", rd, 32'h0000_0002);

        // Flag clears gated by BE[3]
        capture(32'h5);
        opb_write(C_STAT_ADDR, 32'h0000_0003, 4'b1111);
        opb_read(C_STAT_ADDR, rd);
        check("status_cleared", rd, 32'h0003_0000);
        capture(32'h6);
        capture(32'h7);
        opb_write(C_STAT_ADDR, 32'h0000_0003, 4'b1110);
        opb_read(C_STAT_ADDR, rd);
        check("status_be_gated", rd, 32'h0005_0003);
        opb_write(C_DATA_ADDR, 32'hFFFF_FFFF, 4'b1111);
        opb_read(C_DATA_ADDR, rd);
        check("data_write_ignored", rd, 32'h0000_0007);

        // Out-of-window accesses are never acked
        OPB_select = 1'b1; OPB_RNW = 1'b1; OPB_ABus = C_HIGH + 32'h1;
        step();
        check("oow_high", {31'd0, Sl_xferAck}, 32'd0);
        OPB_ABus = C_BASE - 32'h4;
        step();
        check("oow_low", {31'd0, Sl_xferAck}, 32'd0);
        OPB_select = 1'b0;
        step();

        // Counter wrap after 65536 captures
        do_reset();
        last = 32'd0;
        user_data_valid = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            last = $urandom;
            user_data_in = last;
            step();
        end
        user_data_valid = 1'b0;
        opb_read(C_STAT_ADDR, rd);
        check("status_wrap", rd, 32'h0000_0003);

        // Capture on the same edge as a DATA read
        user_data_valid = 1'b1;
        user_data_in    = 32'hA5A5_0001;
        OPB_select = 1'b1; OPB_RNW = 1'b1; OPB_ABus = C_DATA_ADDR;
        step();
        rd = Sl_DBus;
        check("simul_old_data", rd, last);
        user_data_valid = 1'b0;
        OPB_select = 1'b0;
        step();
        opb_read(C_STAT_ADDR, rd);
        check("simul_status", rd, 32'h0001_0003);
        opb_read(C_DATA_ADDR, rd);
        check("simul_new_data", rd, 32'hA5A5_0001);

        // Select held for six cycles: acks in cycles 2, 4 and 6
        OPB_select = 1'b1; OPB_RNW = 1'b1; OPB_ABus = C_STAT_ADDR;
        acks = 6'd0;
        acks[0] = Sl_xferAck;
        for (int i = 1; i < 6; i++) begin
            step();
            acks[i] = Sl_xferAck;
        end
        OPB_select = 1'b0;
        step();
        check("held_select_acks", {26'd0, acks}, {26'd0, 6'b101010});

        // Reset during the hit cycle suppresses the ack
        OPB_select = 1'b1; OPB_RNW = 1'b1; OPB_ABus = C_STAT_ADDR; OPB_Rst = 1'b1;
        step();
        check("rst_hit_ack", {31'd0, Sl_xferAck}, 32'd0);
        OPB_Rst = 1'b0; OPB_select = 1'b0;
        step();
        check("rst_hit_after", {31'd0, Sl_xferAck}, 32'd0);

        // Randomized soak against the model
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 7);
            case (r)
                0, 1:    OPB_ABus = C_DATA_ADDR | $urandom_range(0, 3);
                2, 3:    OPB_ABus = C_STAT_ADDR | $urandom_range(0, 3);
                4:       OPB_ABus = C_BASE + $urandom_range(0, 255);
                5:       OPB_ABus = C_HIGH + $urandom_range(1, 16);
                6:       OPB_ABus = C_BASE - $urandom_range(1, 16);
                default: OPB_ABus = $urandom;
            endcase
            OPB_select      = ($urandom_range(0, 2) != 0);
            OPB_RNW         = $urandom_range(0, 1) != 0;
            OPB_BE          = 4'($urandom_range(0, 15));
            OPB_DBus        = 32'($urandom_range(0, 3));
            OPB_seqAddr     = $urandom_range(0, 1) != 0;
            user_data_valid = ($urandom_range(0, 2) == 0);
            user_data_in    = $urandom;
            OPB_Rst         = ($urandom_range(0, 63) == 0);
            step();
        end
        OPB_Rst = 1'b0; OPB_select = 1'b0; user_data_valid = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
